// File: rtl/axis_mem_word_packer.sv
// rtl/axis_mem_word_packer.sv - AXIS packet to memory-word gearbox with header, oq decode and drop; optional counters via AXIS_MEM_WORD_PACKER_STATS_EN
`timescale 1ns/1ps
module axis_mem_word_packer #(
    parameter int IN_W      = 256,
    parameter int OUT_W     = 192,
    parameter int TUSER_W   = 128,
    parameter int NUM_PORTS = 4,
    parameter int DST_POS   = 24
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         s_tvalid,
    output logic                         s_tready,
    input  logic [IN_W-1:0]              s_tdata,
    input  logic [IN_W/8-1:0]            s_tkeep,
    input  logic [TUSER_W-1:0]           s_tuser,
    input  logic                         s_tlast,
    input  logic                         mem_full,
    output logic                         w_valid,
    input  logic                         w_ready,
    output logic [OUT_W-1:0]             w_data,
    output logic                         w_sof,
    output logic                         w_eof,
    output logic [$clog2(OUT_W/8):0]     w_bytes,
    output logic [NUM_PORTS:0]           w_oq
`ifdef AXIS_MEM_WORD_PACKER_STATS_EN
    ,
    output logic [31:0]                  pkt_cnt,
    output logic [31:0]                  drop_cnt
`endif
);

    localparam int IB     = IN_W / 8;
    localparam int OB     = OUT_W / 8;
    localparam int ACC_W  = IN_W + OUT_W;
    localparam int ACC_B  = ACC_W / 8;
    localparam int FILL_W = $clog2(ACC_B + 1);
    localparam int WB_W   = $clog2(OB) + 1;

    localparam logic [FILL_W-1:0] OB_F = FILL_W'(OB);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_DROP
    } state_t;

    logic [1:0]          rst_sync_q, rst_sync_d;
    logic                rst_int;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic                eop_q, eop_d;
    logic [TUSER_W-1:0]  tuser_q, tuser_d;
    logic [NUM_PORTS:0]  oq_q, oq_d;

    logic [NUM_PORTS:0]  oq_dec;
    logic [FILL_W-1:0]   beat_bytes;
    logic [IN_W-1:0]     beat_data;
    logic [FILL_W-1:0]   emit_bytes;
    logic [ACC_W-1:0]    acc_work;
    logic [FILL_W-1:0]   fill_work;

    // Reset synchroniser input: shift zeros in once the external reset releases
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b0};
    end

    // Reset synchroniser: asserts immediately, releases two clocks after reset drops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_int = rst_sync_q[1];

    // Destination decode: even bits are MAC ports, any odd bit selects the CPU queue
    always_comb begin
        oq_dec = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            oq_dec[i]         = s_tuser[DST_POS + 2*i];
            oq_dec[NUM_PORTS] = oq_dec[NUM_PORTS] | s_tuser[DST_POS + 2*i + 1];
        end
    end

    // Beat byte count and keep-masked data so bytes above fill stay zero in the accumulator
    always_comb begin
        beat_bytes = '0;
        beat_data  = '0;
        for (int i = 0; i < IB; i++) begin
            beat_bytes         = beat_bytes + FILL_W'(s_tkeep[i]);
            beat_data[8*i +: 8] = s_tdata[8*i +: 8] & {8{s_tkeep[i]}};
        end
    end

    // Packet FSM, accumulator update and output generation
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        fill_d     = fill_q;
        eop_d      = eop_q;
        tuser_d    = tuser_q;
        oq_d       = oq_q;
        acc_work   = acc_q;
        fill_work  = fill_q;
        s_tready   = 1'b0;
        w_valid    = 1'b0;
        w_data     = '0;
        w_sof      = 1'b0;
        w_eof      = 1'b0;
        w_bytes    = '0;
        emit_bytes = (fill_q < OB_F) ? fill_q : OB_F;

        unique case (state_q)
            ST_IDLE: begin
                if (s_tvalid) begin
                    if (mem_full || (oq_dec == '0)) begin
                        state_d = ST_DROP;
                    end else begin
                        tuser_d = s_tuser;
                        oq_d    = oq_dec;
                        state_d = ST_HDR;
                    end
                end
            end

            ST_HDR: begin
                w_valid = 1'b1;
                w_data  = OUT_W'(tuser_q);
                w_sof   = 1'b1;
                if (w_ready) begin
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                s_tready = (fill_q < OB_F) && !eop_q;
                w_valid  = (fill_q >= OB_F) || (eop_q && (fill_q != '0));
                w_data   = acc_q[OUT_W-1:0];
                w_eof    = eop_q && (fill_q <= OB_F);
                w_bytes  = w_valid ? WB_W'(emit_bytes) : '0;

                // Emit comes out of the pre-append contents, then the beat lands at the new fill
                if (w_valid && w_ready) begin
                    acc_work  = acc_q >> OUT_W;
                    fill_work = fill_q - emit_bytes;
                end
                if (s_tvalid && s_tready) begin
                    acc_work  = acc_work | (ACC_W'(beat_data) << {fill_work, 3'b000});
                    fill_work = fill_work + beat_bytes;
                    if (s_tlast) begin
                        eop_d = 1'b1;
                    end
                end
                acc_d  = acc_work;
                fill_d = fill_work;

                if (w_valid && w_ready && w_eof) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    fill_d  = '0;
                    eop_d   = 1'b0;
                end else if (eop_q && (fill_q == '0)) begin
                    // Empty tail (all-zero keep on tlast with nothing buffered): nothing left to emit
                    state_d = ST_IDLE;
                    eop_d   = 1'b0;
                end
            end

            ST_DROP: begin
                s_tready = 1'b1;
                if (s_tvalid && s_tlast) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Datapath and state registers
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            fill_q  <= '0;
            eop_q   <= 1'b0;
            tuser_q <= '0;
            oq_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            eop_q   <= eop_d;
            tuser_q <= tuser_d;
            oq_q    <= oq_d;
        end
    end

    assign w_oq = oq_q;

`ifdef AXIS_MEM_WORD_PACKER_STATS_EN
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;

    // Counters: completed packets on eof acceptance, drops on entry to DROP; both wrap
    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if ((state_q == ST_DATA) && w_valid && w_ready && w_eof) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
        end
        if ((state_q == ST_IDLE) && (state_d == ST_DROP)) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_axis_mem_word_packer.sv
// tb/tb_axis_mem_word_packer.sv - scoreboard bench for axis_mem_word_packer
`timescale 1ns/1ps
module tb_axis_mem_word_packer;

    localparam int IN_W      = 256;
    localparam int OUT_W     = 192;
    localparam int TUSER_W   = 128;
    localparam int NUM_PORTS = 4;
    localparam int DST_POS   = 24;
    localparam int IB        = IN_W / 8;
    localparam int OB        = OUT_W / 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 s_tvalid = 1'b0;
    logic                 s_tready;
    logic [IN_W-1:0]      s_tdata = '0;
    logic [IB-1:0]        s_tkeep = '0;
    logic [TUSER_W-1:0]   s_tuser = '0;
    logic                 s_tlast = 1'b0;
    logic                 mem_full = 1'b0;
    logic                 w_valid;
    logic                 w_ready;
    logic [OUT_W-1:0]     w_data;
    logic                 w_sof;
    logic                 w_eof;
    logic [5:0]           w_bytes;
    logic [NUM_PORTS:0]   w_oq;
`ifdef AXIS_MEM_WORD_PACKER_STATS_EN
    logic [31:0]          pkt_cnt;
    logic [31:0]          drop_cnt;
`endif

    axis_mem_word_packer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .TUSER_W(TUSER_W),
        .NUM_PORTS(NUM_PORTS), .DST_POS(DST_POS)
    ) dut (
        .clk(clk), .reset(reset),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tkeep(s_tkeep), .s_tuser(s_tuser), .s_tlast(s_tlast),
        .mem_full(mem_full),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .w_sof(w_sof), .w_eof(w_eof), .w_bytes(w_bytes), .w_oq(w_oq)
`ifdef AXIS_MEM_WORD_PACKER_STATS_EN
        , .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             sof;
        logic             eof;
        logic [5:0]       bytes;
        logic [4:0]       oq;
    } word_t;

    word_t exp_q[$];
    word_t mon_e;
    int checks = 0;
    int errors = 0;
    int words_seen = 0;
    int tready_cycles = 0;
    int ready_mode = 0;
    int ready_phase = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Downstream ready: always 1, or the repeating 1,0,0,1 stall pattern
    initial begin
        w_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) begin
                w_ready = (ready_phase == 0) || (ready_phase == 3);
                ready_phase = (ready_phase + 1) % 4;
            end else begin
                w_ready = 1'b1;
            end
        end
    end

    // Output monitor: every valid cycle must match the scoreboard head; pop on accept
    always @(negedge clk) begin
        if (s_tvalid && s_tready) tready_cycles++;
        if (w_valid) begin
            check_eq("tready_while_valid", s_tready, 0);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_word", w_valid, 0);
            end else begin
                mon_e = exp_q[0];
                check_eq("w_data",  w_data,  mon_e.data);
                check_eq("w_sof",   w_sof,   mon_e.sof);
                check_eq("w_eof",   w_eof,   mon_e.eof);
                check_eq("w_bytes", w_bytes, mon_e.bytes);
                check_eq("w_oq",    w_oq,    mon_e.oq);
                if (w_ready) begin
                    void'(exp_q.pop_front());
                    words_seen++;
                end
            end
        end
    end

    task automatic send_pkt(input int nbytes, input logic [7:0] dst, input bit full,
                            input int seed, input int max_beats);
        logic [TUSER_W-1:0] tu;
        logic [4:0]         oq;
        logic [7:0]         pay[$];
        word_t              w;
        int                 nbeats, rem, t, n;
        tu = {32'hA5A5_0000 + 32'(seed), 32'h1234_5678 ^ 32'(seed), 32'hDEAD_BEEF, 32'h0BAD_F00D};
        tu[DST_POS +: 8] = dst;
        for (int i = 0; i < NUM_PORTS; i++) oq[i] = dst[2*i];
        oq[4] = dst[1] | dst[3] | dst[5] | dst[7];
        for (int i = 0; i < nbytes; i++) pay.push_back(8'(seed * 7 + i * 13 + 1));
        if (!full && (oq != 5'd0)) begin
            w = '0;
            w.data = OUT_W'(tu);
            w.sof = 1'b1;
            w.oq = oq;
            exp_q.push_back(w);
            for (int s = 0; s < nbytes; s += OB) begin
                w = '0;
                n = (nbytes - s < OB) ? nbytes - s : OB;
                for (int k = 0; k < n; k++) w.data[8*k +: 8] = pay[s + k];
                w.bytes = 6'(n);
                w.eof = (s + OB >= nbytes);
                w.oq = oq;
                exp_q.push_back(w);
            end
        end
        nbeats = (nbytes + IB - 1) / IB;
        for (int b = 0; b < nbeats && b < max_beats; b++) begin
            rem = nbytes - b * IB;
            for (int k = 0; k < IB; k++) begin
                s_tdata[8*k +: 8] = (k < rem) ? pay[b * IB + k] : 8'hEE;
                s_tkeep[k] = (k < rem);
            end
            s_tuser = tu;
            s_tlast = (b == nbeats - 1);
            mem_full = full;
            s_tvalid = 1'b1;
            t = 0;
            @(negedge clk);
            while (!s_tready && t < 1000) begin
                @(negedge clk);
                t++;
            end
            if (!s_tready) check_eq("tready_timeout", 0, 1);
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        mem_full = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check_eq("drain", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    int w0;

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_s_tready", s_tready, 0);
        check_eq("rst_w_valid",  w_valid,  0);
        check_eq("rst_w_sof",    w_sof,    0);
        check_eq("rst_w_eof",    w_eof,    0);
        check_eq("rst_w_bytes",  w_bytes,  0);
        check_eq("rst_w_oq",     w_oq,     0);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // 64 B to MAC0
        w0 = words_seen;
        send_pkt(64, 8'h01, 1'b0, 1, 99);
        wait_drain();
        check_eq("words_64B", words_seen - w0, 4);

        // 33 B to CPU0
        w0 = words_seen;
        send_pkt(33, 8'h02, 1'b0, 2, 99);
        wait_drain();
        check_eq("words_33B", words_seen - w0, 3);

        // mem_full drop, 3 beats
        w0 = words_seen;
        tready_cycles = 0;
        send_pkt(96, 8'h01, 1'b1, 3, 99);
        repeat (3) @(posedge clk);
        #1;
        check_eq("drop_full_beats", tready_cycles, 3);
        check_eq("drop_full_words", words_seen - w0, 0);
`ifdef AXIS_MEM_WORD_PACKER_STATS_EN
        check_eq("drop_cnt_1", drop_cnt, 1);
`endif

        // forwarded normally afterwards
        w0 = words_seen;
        send_pkt(64, 8'h04, 1'b0, 4, 99);
        wait_drain();
        check_eq("words_after_drop", words_seen - w0, 4);

        // no queue addressed
        w0 = words_seen;
        tready_cycles = 0;
        send_pkt(96, 8'h00, 1'b0, 5, 99);
        repeat (3) @(posedge clk);
        #1;
        check_eq("drop_dst0_beats", tready_cycles, 3);
        check_eq("drop_dst0_words", words_seen - w0, 0);
`ifdef AXIS_MEM_WORD_PACKER_STATS_EN
        check_eq("drop_cnt_2", drop_cnt, 2);
`endif

        // 96 B with w_ready stalling
        ready_mode = 1;
        w0 = words_seen;
        send_pkt(96, 8'h10, 1'b0, 6, 99);
        wait_drain();
        ready_mode = 0;
        check_eq("words_96B_stall", words_seen - w0, 5);
        repeat (2) @(posedge clk);
        #1;

        // reset in the middle of a 128 B packet
        send_pkt(128, 8'h01, 1'b0, 7, 2);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_eq("midrst_s_tready", s_tready, 0);
        check_eq("midrst_w_valid",  w_valid,  0);
        check_eq("midrst_w_sof",    w_sof,    0);
        check_eq("midrst_w_eof",    w_eof,    0);
        check_eq("midrst_w_bytes",  w_bytes,  0);
        check_eq("midrst_w_oq",     w_oq,     0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        w0 = words_seen;
        send_pkt(64, 8'h01, 1'b0, 1, 99);
        wait_drain();
        check_eq("words_post_reset", words_seen - w0, 4);
`ifdef AXIS_MEM_WORD_PACKER_STATS_EN
        check_eq("pkt_cnt_post_reset", pkt_cnt, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
